// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache with 2-word blocks. It answers datapath
// load/store/LL/SC requests and flushes dirty blocks to memory on halt.
module dcache_responder #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   input  logic        datomic,
   input  logic        halt,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic        dwait,
   input  logic [31:0] dload
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - IDX_W - 3;
   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

   typedef enum logic [3:0] {
      IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH, FLUSH_WB0, FLUSH_WB1, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
   logic             link_valid_q, link_valid_d;
   logic [29:0]      link_addr_q, link_addr_d;
   logic [SETS-1:0]  valid_q, valid_d;
   logic [SETS-1:0]  dirty_q, dirty_d;

   logic [TAG_W-1:0] tag_mem   [SETS];
   logic [31:0]      word0_mem [SETS];
   logic [31:0]      word1_mem [SETS];

   logic [IDX_W-1:0] req_idx, mem_idx;
   logic [TAG_W-1:0] req_tag, mem_tag;
   logic             req_word, hit, link_match;
   logic             word0_we, word1_we, tag_we;
   logic [31:0]      word0_wdata, word1_wdata;
   logic             unused_addr_bits;

   assign req_word   = dmemaddr[2];
   assign req_idx    = dmemaddr[IDX_W+2:3];
   assign req_tag    = dmemaddr[31:IDX_W+3];
   assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign link_match = link_valid_q && (link_addr_q == dmemaddr[31:2]);
   // Write-back of a victim uses the request index; the flush walk uses its own.
   assign mem_idx    = (state_q == FLUSH_WB0 || state_q == FLUSH_WB1) ? flush_idx_q : req_idx;
   assign mem_tag    = tag_mem[mem_idx];
   assign unused_addr_bits = &{1'b0, dmemaddr[1:0]};

   always_comb begin
      state_d      = state_q;
      flush_idx_d  = flush_idx_q;
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      word0_we     = 1'b0;
      word1_we     = 1'b0;
      tag_we       = 1'b0;
      word0_wdata  = dmemstore;
      word1_wdata  = dmemstore;
      dhit         = 1'b0;
      dmemload     = '0;
      flushed      = 1'b0;
      dREN         = 1'b0;
      dWEN         = 1'b0;
      daddr        = '0;
      dstore       = '0;

      case (state_q)
         IDLE: begin
            if (halt) begin
               state_d     = FLUSH;
               flush_idx_d = '0;
            end else if (dmemWEN && datomic && !link_match) begin
               dhit = 1'b1;   // failed SC completes at once and touches nothing
            end else if (dmemREN || dmemWEN) begin
               if (hit) begin
                  dhit = 1'b1;
                  if (dmemWEN) begin
                     word0_we          = !req_word;
                     word1_we          = req_word;
                     dirty_d[req_idx]  = 1'b1;
                     dmemload          = {31'd0, datomic};
                     if (link_match)
                        link_valid_d = 1'b0;
                  end else begin
                     dmemload = req_word ? word1_mem[req_idx] : word0_mem[req_idx];
                     if (datomic) begin
                        link_valid_d = 1'b1;
                        link_addr_d  = dmemaddr[31:2];
                     end
                  end
               end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                  state_d = WB0;
               end else begin
                  state_d = FETCH0;
               end
            end
         end
         WB0, FLUSH_WB0: begin
            dWEN   = 1'b1;
            daddr  = {mem_tag, mem_idx, 3'b000};
            dstore = word0_mem[mem_idx];
            if (!dwait)
               state_d = (state_q == WB0) ? WB1 : FLUSH_WB1;
         end
         WB1, FLUSH_WB1: begin
            dWEN   = 1'b1;
            daddr  = {mem_tag, mem_idx, 3'b100};
            dstore = word1_mem[mem_idx];
            if (!dwait) begin
               if (state_q == WB1) begin
                  state_d = FETCH0;
               end else begin
                  dirty_d[flush_idx_q] = 1'b0;
                  if (flush_idx_q == LAST_IDX) begin
                     state_d = DONE;
                  end else begin
                     flush_idx_d = flush_idx_q + IDX_W'(1);
                     state_d     = FLUSH;
                  end
               end
            end
         end
         FETCH0: begin
            dREN  = 1'b1;
            daddr = {req_tag, req_idx, 3'b000};
            if (!dwait) begin
               word0_we         = 1'b1;
               word0_wdata      = dload;
               valid_d[req_idx] = 1'b0;   // block is half-overwritten until FETCH1 lands
               state_d          = FETCH1;
            end
         end
         FETCH1: begin
            dREN  = 1'b1;
            daddr = {req_tag, req_idx, 3'b100};
            if (!dwait) begin
               word1_we         = 1'b1;
               word1_wdata      = dload;
               tag_we           = 1'b1;
               valid_d[req_idx] = 1'b1;
               dirty_d[req_idx] = 1'b0;
               state_d          = IDLE;
            end
         end
         FLUSH: begin
            if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
               state_d = FLUSH_WB0;
            end else if (flush_idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               flush_idx_d = flush_idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            flushed = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         flush_idx_q  <= '0;
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
      end else begin
         state_q      <= state_d;
         flush_idx_q  <= flush_idx_d;
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (word0_we)
         word0_mem[req_idx] <= word0_wdata;
      if (word1_we)
         word1_mem[req_idx] <= word1_wdata;
      if (tag_we)
         tag_mem[req_idx] <= req_tag;
   end
endmodule

// File: tb/tb_dcache_responder.sv
// Randomised and directed checks of dcache_responder against a flat-memory
// reference with a per-set residency model and a latency-randomised memory.
module tb_dcache_responder;
   localparam int SETS = 16;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        dmemREN, dmemWEN, datomic, halt;
   logic [31:0] dmemaddr, dmemstore;
   logic        dhit, flushed, dREN, dWEN;
   logic [31:0] dmemload, daddr, dstore;
   logic        dwait;
   logic [31:0] dload;

   always #5 CLK = ~CLK;

   dcache_responder #(.SETS(SETS)) dut (
      .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .datomic(datomic), .halt(halt),
      .dhit(dhit), .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload)
   );

   int total = 0;
   int bad   = 0;

   // Backing memory seen by the cache, and the architectural memory the datapath expects.
   logic [31:0] backing [1024];
   logic [31:0] arch    [1024];
   logic [31:0] rd_q[$];
   logic [31:0] wr_a_q[$];
   logic [31:0] wr_d_q[$];
   int mem_lat  = 0;
   bit rand_lat = 1'b0;
   int cnt      = 0;

   assign dload = backing[daddr[11:2]];

   // Memory side: dwait drops for one cycle after mem_lat busy cycles of a held request.
   always @(negedge CLK) begin
      if (!nRST) begin
         dwait = 1'b1;
         cnt   = 0;
      end else if (!dwait) begin
         dwait = 1'b1;
         cnt   = 0;
      end else if (dREN || dWEN) begin
         if (cnt >= mem_lat) begin
            dwait = 1'b0;
            if (dWEN) begin
               backing[daddr[11:2]] = dstore;
               wr_a_q.push_back(daddr);
               wr_d_q.push_back(dstore);
            end else begin
               rd_q.push_back(daddr);
            end
            if (rand_lat) mem_lat = $urandom_range(0, 3);
         end else begin
            cnt++;
         end
      end
   end

   // Reference cache-state model: which tag each set holds and whether it is dirty.
   bit          m_valid [SETS];
   bit          m_dirty [SETS];
   logic [24:0] m_tag   [SETS];
   bit          m_link;
   logic [29:0] m_link_addr;

   function automatic logic [31:0] mem_init(int i);
      return (i * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         m_valid[s] = 1'b0;
         m_dirty[s] = 1'b0;
      end
      m_link = 1'b0;
      for (int i = 0; i < 1024; i++) arch[i] = backing[i];
   endtask

   task automatic model_access(input bit wr, input bit atom, input logic [31:0] addr,
                               input logic [31:0] data, output logic [31:0] exp_ld,
                               output bit exp_hit, output int exp_rd, output int exp_wr);
      int set;
      bit resident;
      set      = int'(addr[6:3]);
      resident = m_valid[set] && (m_tag[set] == addr[31:7]);
      exp_ld   = '0;
      if (wr && atom && !(m_link && m_link_addr == addr[31:2])) begin
         exp_hit = 1'b1;
         exp_rd  = 0;
         exp_wr  = 0;
         return;
      end
      exp_hit = resident;
      exp_rd  = resident ? 0 : 2;
      exp_wr  = (!resident && m_valid[set] && m_dirty[set]) ? 2 : 0;
      if (!resident) begin
         m_valid[set] = 1'b1;
         m_dirty[set] = 1'b0;
         m_tag[set]   = addr[31:7];
      end
      if (wr) begin
         arch[addr[11:2]] = data;
         m_dirty[set]     = 1'b1;
         if (m_link && m_link_addr == addr[31:2]) m_link = 1'b0;
         exp_ld = {31'd0, atom};
      end else begin
         exp_ld = arch[addr[11:2]];
         if (atom) begin
            m_link      = 1'b1;
            m_link_addr = addr[31:2];
         end
      end
   endtask

   task automatic do_req(input bit wr, input bit atom, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] ld,
                         output bit first_hit, output bit timed_out);
      int cycles;
      @(posedge CLK); #1;
      dmemREN = !wr; dmemWEN = wr; datomic = atom; dmemaddr = addr; dmemstore = data;
      first_hit = 1'b0; timed_out = 1'b1; ld = '0; cycles = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         cycles = c + 1;
         if (dhit) begin
            first_hit = (c == 0);
            ld        = dmemload;
            timed_out = 1'b0;
            break;
         end
      end
      @(posedge CLK); #1;
      dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
      $display("req %s%s addr=%08h data=%08h load=%08h first_hit=%0d cycles=%0d",
               atom ? "atomic " : "", wr ? "store" : "load", addr, data, ld, first_hit, cycles);
   endtask

   task automatic apply_reset();
      @(posedge CLK); #1;
      nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0; halt = 1'b0;
      dmemaddr = '0; dmemstore = '0;
      for (int i = 0; i < 1024; i++) backing[i] = mem_init(i);
      repeat (3) @(negedge CLK);
      total++;
      if ({dhit, dREN, dWEN, flushed, dmemload, daddr, dstore} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got dhit=%b dREN=%b dWEN=%b flushed=%b load=%08h daddr=%08h, want all 0",
                  dhit, dREN, dWEN, flushed, dmemload, daddr);
      end
      @(posedge CLK); #1 nRST = 1'b1;
      model_reset();
      @(negedge CLK);
      total++;
      if ({dhit, dREN, dWEN, flushed, dmemload, daddr, dstore} !== '0) begin
         bad++;
         $display("FAIL idle_after_reset: got dhit=%b dREN=%b dWEN=%b flushed=%b, want all 0",
                  dhit, dREN, dWEN, flushed);
      end
   endtask

   task automatic test_cold_load();
      logic [31:0] ld, e_ld;
      bit fh, to, e_hit;
      int e_rd, e_wr;
      backing[16] = 32'hAAAA_0001;
      backing[17] = 32'hBBBB_0002;
      arch[16]    = 32'hAAAA_0001;
      arch[17]    = 32'hBBBB_0002;
      mem_lat = 2;
      rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
      model_access(1'b0, 1'b0, 32'h44, '0, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b0, 1'b0, 32'h44, '0, ld, fh, to);
      total++;
      if (to || fh || ld !== 32'hBBBB_0002) begin
         bad++;
         $display("FAIL cold_load: got load=%08h first_hit=%0d timeout=%0d, want BBBB0002 miss", ld, fh, to);
      end
      total++;
      if (rd_q.size() != 2 || wr_a_q.size() != 0 || rd_q[0] !== 32'h40 || rd_q[1] !== 32'h44) begin
         bad++;
         $display("FAIL cold_fetch_order: got %0d reads %0d writes first=%08h, want reads 40 then 44, no writes",
                  rd_q.size(), wr_a_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'hFFFF_FFFF);
      end
      model_access(1'b0, 1'b0, 32'h40, '0, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b0, 1'b0, 32'h40, '0, ld, fh, to);
      total++;
      if (!fh || ld !== 32'hAAAA_0001) begin
         bad++;
         $display("FAIL reload_hit: got load=%08h first_hit=%0d, want AAAA0001 same-cycle hit", ld, fh);
      end
   endtask

   task automatic test_writeback();
      logic [31:0] ld, e_ld;
      bit fh, to, e_hit;
      int e_rd, e_wr;
      model_access(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, ld, fh, to);
      total++;
      if (!fh) begin
         bad++;
         $display("FAIL store_hit: got first_hit=%0d, want 1", fh);
      end
      rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
      model_access(1'b0, 1'b0, 32'hC0, '0, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b0, 1'b0, 32'hC0, '0, ld, fh, to);
      total++;
      if (wr_a_q.size() != 2 || wr_a_q[0] !== 32'h40 || wr_a_q[1] !== 32'h44 ||
          wr_d_q[0] !== 32'hDEAD_BEEF || wr_d_q[1] !== 32'hBBBB_0002) begin
         bad++;
         $display("FAIL victim_writeback: got %0d writes, want 40=DEADBEEF then 44=BBBB0002", wr_a_q.size());
      end
      total++;
      if (rd_q.size() != 2 || rd_q[0] !== 32'hC0 || rd_q[1] !== 32'hC4 || fh || ld !== mem_init(48)) begin
         bad++;
         $display("FAIL refill_after_wb: got %0d reads load=%08h first_hit=%0d, want C0,C4 load=%08h",
                  rd_q.size(), ld, fh, mem_init(48));
      end
   endtask

   task automatic test_llsc();
      logic [31:0] ld, e_ld;
      bit fh, to, e_hit;
      int e_rd, e_wr;
      model_access(1'b0, 1'b1, 32'h100, '0, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b0, 1'b1, 32'h100, '0, ld, fh, to);
      total++;
      if (to || ld !== mem_init(64)) begin
         bad++;
         $display("FAIL ll_load: got %08h, want %08h", ld, mem_init(64));
      end
      model_access(1'b1, 1'b1, 32'h100, 32'h5, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b1, 1'b1, 32'h100, 32'h5, ld, fh, to);
      total++;
      if (to || ld !== 32'd1) begin
         bad++;
         $display("FAIL sc_success: got %08h, want 00000001", ld);
      end
      model_access(1'b0, 1'b1, 32'h100, '0, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b0, 1'b1, 32'h100, '0, ld, fh, to);
      total++;
      if (!fh || ld !== 32'h5) begin
         bad++;
         $display("FAIL sc_wrote: got %08h first_hit=%0d, want 00000005 hit", ld, fh);
      end
      model_access(1'b1, 1'b0, 32'h100, 32'h7, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b1, 1'b0, 32'h100, 32'h7, ld, fh, to);
      model_access(1'b1, 1'b1, 32'h100, 32'h9, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b1, 1'b1, 32'h100, 32'h9, ld, fh, to);
      total++;
      if (!fh || ld !== 32'd0) begin
         bad++;
         $display("FAIL sc_after_store: got %08h first_hit=%0d, want 00000000 hit", ld, fh);
      end
      model_access(1'b0, 1'b0, 32'h100, '0, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b0, 1'b0, 32'h100, '0, ld, fh, to);
      total++;
      if (ld !== 32'h7) begin
         bad++;
         $display("FAIL sc_fail_nowrite: got %08h, want 00000007", ld);
      end
   endtask

   task automatic test_sc_nolink();
      logic [31:0] ld, e_ld;
      bit fh, to, e_hit;
      int e_rd, e_wr;
      rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
      model_access(1'b1, 1'b1, 32'h200, 32'h77, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b1, 1'b1, 32'h200, 32'h77, ld, fh, to);
      total++;
      if (!fh || ld !== 32'd0 || rd_q.size() != 0 || wr_a_q.size() != 0) begin
         bad++;
         $display("FAIL sc_nolink: got load=%08h first_hit=%0d reads=%0d writes=%0d, want 0, 1, 0, 0",
                  ld, fh, rd_q.size(), wr_a_q.size());
      end
      model_access(1'b0, 1'b0, 32'h200, '0, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b0, 1'b0, 32'h200, '0, ld, fh, to);
      total++;
      if (ld !== mem_init(128)) begin
         bad++;
         $display("FAIL sc_nolink_nowrite: got %08h, want %08h", ld, mem_init(128));
      end
   endtask

   task automatic test_random();
      logic [31:0] ld, e_ld, addr, data, last_ll;
      bit fh, to, e_hit, wr, atom;
      int e_rd, e_wr, nr0, nw0, op;
      rand_lat = 1'b1;
      mem_lat  = $urandom_range(0, 3);
      last_ll  = 32'h0;
      for (int n = 0; n < 300; n++) begin
         op   = $urandom_range(0, 9);
         addr = {20'd0, 10'($urandom_range(0, 255)), 2'b00};
         data = $urandom;
         wr   = (op >= 5 && op <= 7) || op == 9;
         atom = (op >= 8);
         if (op == 8) last_ll = addr;
         if (op == 9 && $urandom_range(0, 1) == 1) addr = last_ll;
         nr0 = rd_q.size();
         nw0 = wr_a_q.size();
         model_access(wr, atom, addr, data, e_ld, e_hit, e_rd, e_wr);
         do_req(wr, atom, addr, data, ld, fh, to);
         total++;
         if (to || fh != e_hit) begin
            bad++;
            $display("FAIL rand_hit op%0d addr=%08h: got first_hit=%0d timeout=%0d, want %0d", n, addr, fh, to, e_hit);
         end
         if (!wr || atom) begin
            total++;
            if (ld !== e_ld) begin
               bad++;
               $display("FAIL rand_load op%0d addr=%08h: got %08h, want %08h", n, addr, ld, e_ld);
            end
         end
         total++;
         if (rd_q.size() - nr0 != e_rd || wr_a_q.size() - nw0 != e_wr) begin
            bad++;
            $display("FAIL rand_traffic op%0d addr=%08h: got reads=%0d writes=%0d, want %0d %0d",
                     n, addr, rd_q.size() - nr0, wr_a_q.size() - nw0, e_rd, e_wr);
         end
      end
      rand_lat = 1'b0;
      mem_lat  = 1;
   endtask

   task automatic wait_flushed(input string name);
      bit done;
      done = 1'b0;
      @(posedge CLK); #1 halt = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         if (flushed) begin
            done = 1'b1;
            break;
         end
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s_timeout: flushed never rose", name);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         total++;
         if (!flushed || dREN || dWEN || dhit) begin
            bad++;
            $display("FAIL %s_sticky: got flushed=%b dREN=%b dWEN=%b dhit=%b, want 1 0 0 0",
                     name, flushed, dREN, dWEN, dhit);
         end
      end
   endtask

   task automatic test_flush_all();
      int diffs;
      wait_flushed("flush_all");
      diffs = 0;
      for (int i = 0; i < 256; i++) if (backing[i] !== arch[i]) diffs++;
      total++;
      if (diffs != 0) begin
         bad++;
         $display("FAIL flush_all_memory: got %0d words differing from reference, want 0", diffs);
      end
      apply_reset();
   endtask

   task automatic test_flush_sets();
      logic [31:0] ld, e_ld, w19;
      bit fh, to, e_hit;
      int e_rd, e_wr;
      model_access(1'b1, 1'b0, 32'h18, 32'hA1A1_0001, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b1, 1'b0, 32'h18, 32'hA1A1_0001, ld, fh, to);
      model_access(1'b1, 1'b0, 32'h1C, 32'hA2A2_0002, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b1, 1'b0, 32'h1C, 32'hA2A2_0002, ld, fh, to);
      model_access(1'b1, 1'b0, 32'h48, 32'hB1B1_0003, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b1, 1'b0, 32'h48, 32'hB1B1_0003, ld, fh, to);
      model_access(1'b0, 1'b0, 32'h28, '0, e_ld, e_hit, e_rd, e_wr);
      do_req(1'b0, 1'b0, 32'h28, '0, ld, fh, to);
      w19 = arch[19];
      rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
      wait_flushed("flush_sets");
      total++;
      if (wr_a_q.size() != 4 || rd_q.size() != 0 ||
          wr_a_q[0] !== 32'h18 || wr_d_q[0] !== 32'hA1A1_0001 ||
          wr_a_q[1] !== 32'h1C || wr_d_q[1] !== 32'hA2A2_0002 ||
          wr_a_q[2] !== 32'h48 || wr_d_q[2] !== 32'hB1B1_0003 ||
          wr_a_q[3] !== 32'h4C || wr_d_q[3] !== w19) begin
         bad++;
         $display("FAIL flush_order: got %0d writes %0d reads, want 18,1C,48,4C with stored data and no reads",
                  wr_a_q.size(), rd_q.size());
      end
      apply_reset();
   endtask

   task automatic test_reset_mid_fetch();
      logic [31:0] ld;
      bit fh, to, seen;
      mem_lat = 3;
      seen = 1'b0;
      @(posedge CLK); #1;
      dmemREN = 1'b1; dmemaddr = 32'h80;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (dREN && daddr == 32'h84) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL mid_fetch_reach: FETCH1 request for 00000084 never seen");
      end
      #1 nRST = 1'b0;
      #1;
      total++;
      if (dREN || dWEN || dhit || daddr !== '0) begin
         bad++;
         $display("FAIL mid_fetch_reset: got dREN=%b dWEN=%b dhit=%b daddr=%08h, want all 0",
                  dREN, dWEN, dhit, daddr);
      end
      dmemREN = 1'b0;
      @(posedge CLK); #1 nRST = 1'b1;
      model_reset();
      rd_q.delete();
      do_req(1'b0, 1'b0, 32'h80, '0, ld, fh, to);
      total++;
      if (to || fh || ld !== arch[32] || rd_q.size() != 2) begin
         bad++;
         $display("FAIL reload_after_reset: got load=%08h first_hit=%0d reads=%0d, want %08h miss with 2 reads",
                  ld, fh, rd_q.size(), arch[32]);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cold_load();
      test_writeback();
      test_llsc();
      test_sc_nolink();
      test_random();
      test_flush_all();
      test_flush_sets();
      test_reset_mid_fetch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
